// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// instruction handoff to decode/execute and the status outputs.
//
// Handshakes:
//   imem: imem_req pulses for one cycle with imem_addr; the memory answers
//         later with a single imem_rvalid beat carrying imem_rdata, and
//         imem_err is meaningful only while imem_rvalid is high.
//   decode: instr_valid stays high with Instr/PC stable until the cycle
//         where instr_ready is also high; that cycle retires the
//         instruction. PCSrc/PCTarget are sampled only in that cycle.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] Instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] instret;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, Instr, instr_valid, PC, PCPlus4,
           fault, fault_cause, instret,
    input  imem_rvalid, imem_rdata, imem_err, instr_ready, PCSrc, PCTarget
  );

  // Memory / datapath side
  modport slave (
    input  imem_req, imem_addr, Instr, instr_valid, PC, PCPlus4,
           fault, fault_cause, instret,
    output imem_rvalid, imem_rdata, imem_err, instr_ready, PCSrc, PCTarget
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one-beat fetches to a
// variable-latency memory, presents the fetched word to decode, applies
// the next-PC choice on retire, traps misaligned targets and bus errors,
// and counts retired instructions.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        bus,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] pc_plus4;
  logic        retire;

  assign pc_plus4 = pc_q + 32'd4;
  // Only a ready seen while presenting an instruction counts as retire
  assign retire   = (state_q == S_VALID) && bus.instr_ready;

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instret_q <= 32'd0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
    end
  end

  // Next-state and register updates; everything holds unless a case moves it
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    cause_d   = cause_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      // Any rvalid seen here is a leftover and is ignored
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          if (bus.imem_err) begin
            cause_d = 2'b01;
            state_d = S_FAULT;
          end else begin
            instr_d = bus.imem_rdata;
            state_d = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (retire) begin
          instret_d = instret_q + 32'd1;
          if (!bus.PCSrc) begin
            pc_d    = pc_plus4;
            state_d = S_REQ;
          end else if (bus.PCTarget[1:0] == 2'b00) begin
            pc_d    = bus.PCTarget;
            state_d = S_REQ;
          end else begin
            // PC keeps the address of the instruction that jumped badly
            cause_d = 2'b10;
            state_d = S_FAULT;
          end
        end
      end
      // Only reset leaves FAULT
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    bus.imem_req    = (state_q == S_REQ);
    bus.instr_valid = (state_q == S_VALID);
    bus.fault       = (state_q == S_FAULT);
  end

  assign bus.imem_addr   = pc_q;
  assign bus.PC          = pc_q;
  assign bus.PCPlus4     = pc_plus4;
  assign bus.Instr       = instr_q;
  assign bus.fault_cause = cause_q;
  assign bus.instret     = instret_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a transaction-level model of the fetch stage
// (current PC, held instruction, retire count, fault cause, and which part
// of a fetch is in progress) is stepped from the inputs the bench drives,
// and every cycle's outputs are compared against it. Directed phases pin
// the model with literal expectations; a randomized phase follows.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam int P_IDLE  = 0;
  localparam int P_REQ   = 1;
  localparam int P_WAIT  = 2;
  localparam int P_VALID = 3;
  localparam int P_FAULT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_instret;
  logic [1:0]  m_cause;
  int          wdelay;

  // Stimulus knobs (percentages; k_lat < 0 means random latency)
  int          k_ready, k_src, k_mis, k_err, k_stray, k_lat;
  bit          k_data_fixed, k_target_fixed;
  logic [31:0] k_data, k_target;

  // Scoreboard of observed request addresses and last presented word
  logic [31:0] exp_q[$];
  logic [31:0] last_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_phase   = P_IDLE;
    m_pc      = RESET_PC;
    m_instr   = 32'h0000_0013;
    m_instret = 32'd0;
    m_cause   = 2'b00;
    wdelay    = 0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    chk("imem_req",    32'(bus.imem_req),    32'(m_phase == P_REQ));
    chk("imem_addr",   bus.imem_addr,        m_pc);
    chk("Instr",       bus.Instr,            m_instr);
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_phase == P_VALID));
    chk("PC",          bus.PC,               m_pc);
    chk("PCPlus4",     bus.PCPlus4,          m_pc + 32'd4);
    chk("fault",       32'(bus.fault),       32'(m_phase == P_FAULT));
    chk("fault_cause", 32'(bus.fault_cause), 32'(m_cause));
    chk("instret",     bus.instret,          m_instret);
    if (bus.imem_req) exp_q.push_back(bus.imem_addr);
    if (bus.instr_valid) last_instr = bus.Instr;
  endtask

  // Driver: choose this cycle's inputs, then advance the model to the next edge
  task automatic drive_and_predict();
    logic        rv, er;
    logic [31:0] rd;
    rv = 1'b0;
    er = 1'b0;
    rd = $urandom;
    bus.instr_ready = ($urandom_range(0, 99) < k_ready);
    bus.PCSrc       = ($urandom_range(0, 99) < k_src);
    if (k_target_fixed) bus.PCTarget = k_target;
    else if ($urandom_range(0, 99) < k_mis)
      bus.PCTarget = ($urandom & ~32'd3) | 32'($urandom_range(1, 3));
    else
      bus.PCTarget = $urandom & ~32'd3;
    if (m_phase == P_WAIT) begin
      if (wdelay == 0) begin
        rv = 1'b1;
        er = ($urandom_range(0, 99) < k_err);
        if (k_data_fixed) rd = k_data;
      end else begin
        wdelay--;
      end
    end else begin
      rv = ($urandom_range(0, 99) < k_stray);
      er = ($urandom_range(0, 1) == 1);
    end
    if (!rv) er = ($urandom_range(0, 1) == 1);
    bus.imem_rvalid = rv;
    bus.imem_err    = er;
    bus.imem_rdata  = rd;

    case (m_phase)
      P_IDLE: m_phase = P_REQ;
      P_REQ: begin
        m_phase = P_WAIT;
        wdelay  = (k_lat >= 0) ? k_lat : int'($urandom_range(0, 3));
      end
      P_WAIT: begin
        if (rv) begin
          if (er) begin
            m_cause = 2'b01;
            m_phase = P_FAULT;
          end else begin
            m_instr = rd;
            m_phase = P_VALID;
          end
        end
      end
      P_VALID: begin
        if (bus.instr_ready) begin
          m_instret = m_instret + 32'd1;
          if (!bus.PCSrc) begin
            m_pc    = m_pc + 32'd4;
            m_phase = P_REQ;
          end else if (bus.PCTarget % 4 == 0) begin
            m_pc    = bus.PCTarget;
            m_phase = P_REQ;
          end else begin
            m_cause = 2'b10;
            m_phase = P_FAULT;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    drive_and_predict();
  endtask

  // Reset mid-cycle with a stale memory beat present; outputs must clear at once
  task automatic do_reset();
    @(negedge clk);
    reset           = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_err    = 1'b0;
    bus.imem_rdata  = $urandom;
    bus.instr_ready = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1 check_outputs();
    @(negedge clk);
    reset = 1'b0;
    drive_and_predict();
  endtask

  task automatic wait_phase(input int p, input int budget, input string name);
    int i;
    i = 0;
    while (m_phase != p && i < budget) begin
      step();
      i++;
    end
    if (m_phase != p) bound_fail(name);
  endtask

  task automatic wait_instret(input logic [31:0] n, input int budget, input string name);
    int i;
    i = 0;
    while (m_instret != n && i < budget) begin
      step();
      i++;
    end
    if (m_instret != n) bound_fail(name);
  endtask

  initial begin
    int n_req;
    int fault_cycles;
    reset           = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_err    = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus.instr_ready = 1'b0;
    bus.PCSrc       = 1'b0;
    bus.PCTarget    = 32'd0;
    last_instr      = 32'd0;

    // 1) steady sequential fetch, memory answers 2 cycles after each request
    k_ready = 100; k_src = 0; k_mis = 0; k_err = 0; k_stray = 0; k_lat = 1;
    k_data_fixed = 1'b1; k_data = 32'h0050_0093;
    k_target_fixed = 1'b0; k_target = 32'd0;
    do_reset();
    wait_instret(32'd3, 100, "t1_wait");
    step();
    chk("t1_nreq",   32'(exp_q.size() >= 3), 32'd1);
    if (exp_q.size() >= 3) begin
      chk("t1_addr0", exp_q[0], 32'h0000_0000);
      chk("t1_addr1", exp_q[1], 32'h0000_0004);
      chk("t1_addr2", exp_q[2], 32'h0000_0008);
    end
    chk("t1_instr",   last_instr,  32'h0050_0093);
    chk("t1_instret", bus.instret, 32'd3);

    // 2) taken branch to an aligned target
    k_src = 100; k_target_fixed = 1'b1; k_target = 32'h0000_0100;
    wait_instret(32'd4, 50, "t2_retire");
    k_src = 0; k_ready = 0;
    wait_phase(P_VALID, 50, "t2_valid");
    step();
    chk("t2_addr",    exp_q[$],        32'h0000_0100);
    chk("t2_pcplus4", bus.PCPlus4,     32'h0000_0104);
    chk("t2_valid",   32'(bus.instr_valid), 32'd1);

    // 5) stall in VALID: everything holds, no new request
    n_req = exp_q.size();
    repeat (10) step();
    chk("t5_nreq",  32'(exp_q.size()), 32'(n_req));
    chk("t5_instr", bus.Instr, 32'h0050_0093);
    chk("t5_pc",    bus.PC,    32'h0000_0100);
    chk("t5_valid", 32'(bus.instr_valid), 32'd1);

    // 3) misaligned target traps; instruction still counts
    k_ready = 100; k_src = 100; k_target = 32'h0000_0102;
    step();
    step();
    chk("t3_fault",   32'(bus.fault),       32'd1);
    chk("t3_cause",   32'(bus.fault_cause), 32'd2);
    chk("t3_pc",      bus.PC,               32'h0000_0100);
    chk("t3_instret", bus.instret,          32'd5);
    n_req = exp_q.size();
    repeat (5) step();
    chk("t3_nreq", 32'(exp_q.size()), 32'(n_req));

    // 4) bus error, with stray beats in IDLE/REQ that must be dropped
    k_src = 0; k_target_fixed = 1'b0; k_err = 100; k_stray = 100; k_lat = 0;
    do_reset();
    wait_phase(P_FAULT, 50, "t4_fault");
    step();
    chk("t4_fault", 32'(bus.fault),       32'd1);
    chk("t4_cause", 32'(bus.fault_cause), 32'd1);
    chk("t4_valid", 32'(bus.instr_valid), 32'd0);
    chk("t4_nreq",  32'(exp_q.size()),    32'd1);
    chk("t4_instr", bus.Instr,            32'h0000_0013);

    // 6) reset in the middle of a fetch, stale beat during reset
    k_err = 0; k_stray = 0; k_lat = 3; k_data_fixed = 1'b0;
    do_reset();
    wait_phase(P_REQ, 20, "t6_req1");
    step();
    wait_phase(P_WAIT, 20, "t6_wait");
    step();
    do_reset();
    step();
    chk("t6_nreq", 32'(exp_q.size() >= 1), 32'd1);
    if (exp_q.size() >= 1) chk("t6_addr", exp_q[0], RESET_PC);

    // Randomized traffic with occasional resets
    k_ready = 60; k_src = 25; k_mis = 10; k_err = 3; k_stray = 20; k_lat = -1;
    fault_cycles = 0;
    for (int c = 0; c < 4000; c++) begin
      if ((m_phase == P_FAULT && fault_cycles > 4) || $urandom_range(0, 499) == 0) begin
        do_reset();
        fault_cycles = 0;
      end else begin
        step();
        if (m_phase == P_FAULT) fault_cycles++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
